// File: rtl/btn_debounce_core.sv
// Push-button debouncer for an FPro MMIO slot: two-flop synchronizer and stability
// counter per button, sticky write-1-to-clear rise/fall flags, and a masked level interrupt.
module btn_debounce_core #(
  parameter int W      = 5,
  parameter int DB_CNT = 1_000_000
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cs,
  input  logic          read,
  input  logic          write,
  input  logic [4:0]    addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  input  logic [W-1:0]  btn,
  output logic [W-1:0]  db_level,
  output logic          irq
);

  localparam int CW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CNT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] A_LEVEL = 3'd0;
  localparam logic [2:0] A_RISE  = 3'd1;
  localparam logic [2:0] A_FALL  = 3'd2;
  localparam logic [2:0] A_RAW   = 3'd3;
  localparam logic [2:0] A_MASK  = 3'd4;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } db_state_e;

  logic [W-1:0] s1_q, s1_d;
  logic [W-1:0] s2_q, s2_d;
  logic [W-1:0] db_q, db_d;
  logic [W-1:0] db_prev_q, db_prev_d;
  logic [W-1:0] rise_q, rise_d;
  logic [W-1:0] fall_q, fall_d;
  logic [W-1:0] mask_q, mask_d;
  logic         irq_q, irq_d;

  logic         wr_en;
  logic [W-1:0] wr_bits;
  logic [W-1:0] rise_set, fall_set;
  logic [W-1:0] rise_clr, fall_clr;
  logic         unused_inputs;

  assign wr_en   = cs & write;
  assign wr_bits = wr_data[W-1:0];

  always_comb begin
    s1_d = btn;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  // One independent stability counter per button; the state mirrors cnt == 0.
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_btn
      db_state_e     state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          db_bit_d;

      always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        db_bit_d = db_q[gi];
        case (state_q)
          ST_STABLE: begin
            if (s2_q[gi] != db_q[gi]) begin
              state_d = ST_COUNTING;
              cnt_d   = CNT_ONE;
            end
          end
          ST_COUNTING: begin
            if (s2_q[gi] == db_q[gi]) begin
              state_d = ST_STABLE;
              cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
              db_bit_d = s2_q[gi];
              state_d  = ST_STABLE;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end
        endcase
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          state_q <= ST_STABLE;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      assign db_d[gi] = db_bit_d;
    end
  endgenerate

  // Flags compare db against its previous value, so they land one edge after db flips.
  always_comb begin
    db_prev_d = db_q;
    rise_set  = db_q & ~db_prev_q;
    fall_set  = ~db_q & db_prev_q;
    rise_clr  = (wr_en && addr[2:0] == A_RISE) ? wr_bits : '0;
    fall_clr  = (wr_en && addr[2:0] == A_FALL) ? wr_bits : '0;
    rise_d    = (rise_q & ~rise_clr) | rise_set;
    fall_d    = (fall_q & ~fall_clr) | fall_set;
    mask_d    = (wr_en && addr[2:0] == A_MASK) ? wr_bits : mask_q;
    irq_d     = |(rise_q & mask_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_q      <= '0;
      db_prev_q <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      mask_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      mask_q    <= mask_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr[2:0])
      A_LEVEL: rd_data[W-1:0] = db_q;
      A_RISE:  rd_data[W-1:0] = rise_q;
      A_FALL:  rd_data[W-1:0] = fall_q;
      A_RAW:   rd_data[W-1:0] = s2_q;
      A_MASK:  rd_data[W-1:0] = mask_q;
      default: rd_data = '0;
    endcase
  end

  assign db_level = db_q;
  assign irq      = irq_q;

  // Reads have no side effects and only the low address bits are decoded.
  assign unused_inputs = ^{read, addr[4:3], wr_data};

endmodule
